constraint_search_ctrl: RTL

Sequential search controller that drives a combinational constraint-checker netlist (packed variable vector in, single `sat` bit out). It generates pseudo-random candidate assignments from a 32-bit LFSR, fills the checker input one 32-bit word per cycle, and evaluates `sat`. It stops on the first satisfying candidate or after `MAX_TRIES` misses. The block sits between the test/solver host and the generated checker module; the checker is instantiated outside this block.

---
 rtl/constraint_search_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/constraint_search_ctrl.sv
// Random-search controller: fills a constraint checker input from a Galois LFSR
// one 32-bit word per cycle. It stops on the first satisfying candidate or once
// the try budget is spent.
module constraint_search_ctrl #(
   parameter int unsigned VEC_W     = 224,
   parameter int unsigned MAX_TRIES = 1024,
   parameter logic [31:0] SEED      = 32'hACE1_0001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   output logic [VEC_W-1:0] cand_o,
   input  logic             sat_i,
   output logic             sol_valid,
   input  logic             sol_ready,
   output logic [VEC_W-1:0] sol_data,
   output logic             busy,
   output logic             fail,
   output logic [15:0]      tries
);

   localparam int unsigned WORDS  = (VEC_W + 31) / 32;
   localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] TAPS   = 32'h8020_0003;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CHECK,
      S_DONE,
      S_FAIL
   } state_t;

   state_t           state;
   logic [31:0]      lfsr;
   logic [CNT_W-1:0] fill_cnt;
   logic             last_try_c;

   // One Galois step: shift right, fold taps in when a 1 falls out
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      lfsr_step = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
   endfunction

   // This miss would be the final one the budget allows
   assign last_try_c = ((17'(tries) + 17'd1) == 17'(MAX_TRIES));

   // Search FSM with registered outputs; abort overrides all other activity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         lfsr      <= SEED;
         fill_cnt  <= '0;
         cand_o    <= '0;
         tries     <= '0;
         sol_valid <= 1'b0;
         sol_data  <= '0;
         busy      <= 1'b0;
         fail      <= 1'b0;
      end else if (abort && (state != S_IDLE)) begin
         state     <= S_IDLE;
         sol_valid <= 1'b0;
         sol_data  <= '0;
         busy      <= 1'b0;
         fail      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (seed_load) begin
                  lfsr <= (seed_in != 32'd0) ? seed_in : SEED;
               end
               if (start) begin
                  tries    <= '0;
                  fill_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= S_FILL;
               end
            end
            S_FILL: begin
               cand_o <= VEC_W'({cand_o, lfsr});
               lfsr   <= lfsr_step(lfsr);
               if (fill_cnt == CNT_W'(WORDS - 1)) begin
                  state <= S_CHECK;
               end else begin
                  fill_cnt <= fill_cnt + CNT_W'(1);
               end
            end
            S_CHECK: begin
               if (sat_i) begin
                  busy      <= 1'b0;
                  sol_valid <= 1'b1;
                  sol_data  <= cand_o;
                  state     <= S_DONE;
               end else if (last_try_c) begin
                  tries <= tries + 16'd1;
                  busy  <= 1'b0;
                  fail  <= 1'b1;
                  state <= S_FAIL;
               end else begin
                  tries    <= tries + 16'd1;
                  fill_cnt <= '0;
                  state    <= S_FILL;
               end
            end
            S_DONE: begin
               if (sol_ready) begin
                  sol_valid <= 1'b0;
                  sol_data  <= '0;
                  state     <= S_IDLE;
               end
            end
            S_FAIL: begin
               fail  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
